// File: rtl/hk_sram_burst_reader.sv
// Burst reader for the housekeeping SRAM port: it fetches 32-bit words and streams them out as bytes.
// Define HK_SRAM_BSWAP_EN to emit each word MSB first. By default the LSB is emitted first.
module hk_sram_burst_reader (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [7:0]  req_cnt,
    input  logic        abort,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        busy,
    output logic        hkspi_sram_clk,
    output logic        hkspi_sram_csb,
    output logic [7:0]  hkspi_sram_addr,
    input  logic [31:0] hkspi_sram_rdata
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] CLKHI = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] SHIFT = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic        clk_q, clk_d;
    logic        csb_q, csb_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        idx_d   = idx_q;
        clk_d   = clk_q;
        csb_d   = csb_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    addr_d  = req_addr;
                    cnt_d   = req_cnt;
                    csb_d   = 1'b0;
                end
            end
            SETUP: begin
                state_d = CLKHI;
                clk_d   = 1'b1;
            end
            CLKHI: begin
                state_d = READ;
                clk_d   = 1'b0;
            end
            READ: begin
                state_d = SHIFT;
                word_d  = hkspi_sram_rdata;
                idx_d   = 2'd0;
            end
            SHIFT: begin
                if (byte_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (cnt_q == 8'd0) begin
                            state_d = IDLE;
                            csb_d   = 1'b1;
                        end else begin
                            // The address wraps modulo 256. csb stays low between words.
                            state_d = SETUP;
                            cnt_d   = cnt_q - 8'd1;
                            addr_d  = addr_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
                csb_d   = 1'b1;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            clk_d   = 1'b0;
            csb_d   = 1'b1;
            word_d  = 32'h0;
            idx_d   = 2'd0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q <= IDLE;
            addr_q  <= 8'h00;
            cnt_q   <= 8'h00;
            word_q  <= 32'h0;
            idx_q   <= 2'd0;
            clk_q   <= 1'b0;
            csb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            clk_q   <= clk_d;
            csb_q   <= csb_d;
        end
    end

    always_comb begin
        byte_data = 8'h00;
`ifdef HK_SRAM_BSWAP_EN
        case (idx_q)
            2'd0:    byte_data = word_q[31:24];
            2'd1:    byte_data = word_q[23:16];
            2'd2:    byte_data = word_q[15:8];
            default: byte_data = word_q[7:0];
        endcase
`else
        case (idx_q)
            2'd0:    byte_data = word_q[7:0];
            2'd1:    byte_data = word_q[15:8];
            2'd2:    byte_data = word_q[23:16];
            default: byte_data = word_q[31:24];
        endcase
`endif
    end

    assign req_ready       = (state_q == IDLE) && !core_rst;
    assign busy            = (state_q != IDLE);
    assign byte_valid      = (state_q == SHIFT);
    assign byte_last       = byte_valid && (idx_q == 2'd3) && (cnt_q == 8'd0);
    assign hkspi_sram_clk  = clk_q;
    assign hkspi_sram_csb  = csb_q;
    assign hkspi_sram_addr = addr_q;

endmodule

// File: doc/hk_sram_burst_reader.md
# hk_sram_burst_reader

Burst read sequencer for the housekeeping read-only SRAM port of the management core wrapper. Accepts a (start address, word count) request from the housekeeping SPI logic and drives hkspi_sram_clk/csb/addr with a self-generated clock pulse per word. Captures hkspi_sram_rdata and streams it out as a valid/ready byte stream, four bytes per word, tagged with a last flag. Sits between the housekeeping SPI command decoder (upstream consumer of bytes) and the wrapper's hkspi_sram_* port.

## Interface
- No parameters; widths fixed by the 256 x 32 SRAM.
- core_clk  in  1  single clock; all state on rising edge.
- core_rst  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request strobe.
- req_ready  out  1  high when idle and not in reset (`state==IDLE && !core_rst`).
- req_addr  in  8  start word address.
- req_cnt  in  8  words minus one (0 = 1 word, 255 = 256 words).
- abort  in  1  terminate burst; takes priority over all other activity.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  consumer accepts byte.
- byte_data  out  8  stream byte.
- byte_last  out  1  final byte of the burst.
- busy  out  1  state != IDLE.
- hkspi_sram_clk  out  1  SRAM read clock (registered).
- hkspi_sram_csb  out  1  SRAM chip select, active low (registered).
- hkspi_sram_addr  out  8  SRAM word address (registered).
- hkspi_sram_rdata  in  32  SRAM read data.

## Operation
- States: IDLE, SETUP, CLKHI, READ, SHIFT.
- IDLE: csb=1, clk=0. On req_valid && req_ready: latch addr, cnt; go SETUP.
- SETUP: csb=0, addr driven, clk=0 -> CLKHI.
- CLKHI: clk=1 (SRAM samples address) -> READ.
- READ: clk=0; at end of cycle register hkspi_sram_rdata into word buffer, set byte index 0, byte_valid=1 -> SHIFT.
- SHIFT: present byte index i; on byte_valid && byte_ready advance i. After accepting byte 3: if remaining count = 0 -> IDLE (csb=1, byte_valid=0); else decrement count, addr+1 -> SETUP (csb stays low).
- Byte order (default): i=0 -> rdata[7:0], i=1 -> [15:8], i=2 -> [23:16], i=3 -> [31:24].
- byte_last = 1 only on byte 3 of the final word.
- Address arithmetic is 8-bit modulo: 0xFF + 1 = 0x00; a 256-word burst from any address reads every word once.
- byte_data/byte_last hold stable while byte_valid && !byte_ready.
- abort (any state): next cycle IDLE, csb=1, clk=0, byte_valid=0, byte_last=0; buffered data discarded. abort with req_valid in IDLE: request not accepted.
- req_valid ignored outside IDLE.

## Timing
- Reset values: req_ready=0 during reset, 1 the cycle after; busy=0, hkspi_sram_clk=0, hkspi_sram_csb=1, hkspi_sram_addr=0x00, byte_valid=0, byte_data=0x00, byte_last=0.
- Accept on edge N -> csb low, addr valid after N+1; clk high after N+2; clk low after N+3; byte_valid after N+3... precisely: SETUP visible cycle N+1, CLKHI N+2, READ N+3, first byte_valid in cycle N+4 (captured at end of READ).
- Address setup to clk rise: 1 cycle; rdata sampled 1 full cycle after clk rise.
- With byte_ready held high: 4 byte cycles + 3 fetch cycles = 7 cycles per word; burst of k words ends with byte_last in cycle N+7k.
- Reset mid-burst behaves as abort plus full output reset.

## Configuration
- HK_SRAM_BSWAP_EN defined: bytes within each word emitted MSB first (i=0 -> rdata[31:24] ... i=3 -> rdata[7:0]), matching big-endian SPI readback. Undefined: little-endian order above. No other behaviour changes.

## Test plan
- Single word: SRAM[0x10]=0xA1B2C3D4, req_addr=0x10, req_cnt=0, byte_ready=1 -> bytes D4,C3,B2,A1 (A1,B2,C3,D4 with HK_SRAM_BSWAP_EN), byte_last only on 4th, first byte cycle N+4, csb high after.
- Wrap: req_addr=0xFE, req_cnt=2 -> hkspi_sram_addr sequence FE,FF,00; 12 bytes; csb low continuously across burst.
- Backpressure: toggle byte_ready randomly during 4-word burst -> no dropped/duplicated bytes, byte_data stable while stalled, no SRAM clock pulse until byte 3 of previous word accepted.
- Abort mid-SHIFT of word 2 of 4 -> next cycle byte_valid=0, csb=1, busy=0, req_ready=1; new request then returns correct data.
- Full burst: req_addr=0x37, req_cnt=0xFF with SRAM[i]=i*0x01010101 -> 1024 bytes, every address once, byte_last on byte 1024 only.
- Reset asserted in CLKHI -> following cycle all outputs at reset values; req_valid during IDLE ignored while core_rst=1.
